// File: rtl/class_score_acc_if.sv
// Handshake bundle between the XNOR beat source, the score accumulator and the argmax consumer.
interface class_score_acc_if #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4,
    parameter int unsigned W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_bits;
    logic           out_valid;
    logic           out_ready;
    logic [N*K-1:0] out_scores;
    logic [N-1:0]   out_overflow;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_scores, out_overflow
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_scores, out_overflow
    );
endinterface

// File: rtl/class_score_acc.sv
// Per-class popcount accumulator over BEATS beats; presents saturated K-bit scores
// plus overflow flags to the argmax stage under a valid/ready handshake.
module class_score_acc #(
    parameter int unsigned N     = 8,
    parameter int unsigned K     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned BEATS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    class_score_acc_if.slave bus
);
    localparam int unsigned A    = $clog2(W * BEATS + 1);
    localparam int unsigned PW   = $clog2(W + 1);
    localparam int unsigned CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SMAX = (2 ** K) - 1;

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N-1:0][A-1:0]  acc_q, acc_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [N*K-1:0]       scores_q, scores_d;
    logic [N-1:0]         ovf_q, ovf_d;

    function automatic logic [PW-1:0] popcnt(input logic [W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int unsigned b = 0; b < W; b++) begin
            c = c + PW'(v[b]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            scores_q    <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            scores_q    <= scores_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state; score outputs are registered copies of the saturated next accumulators.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        scores_d    = '0;
        ovf_d       = '0;

        unique case (state_q)
            ACC: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        acc_d[i] = acc_q[i] + A'(popcnt(bus.in_bits[i*W +: W]));
                    end
                    if (cnt_q == CW'(BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase

        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == HOLD);
        for (int unsigned i = 0; i < N; i++) begin
            ovf_d[i]            = (32'(acc_d[i]) > SMAX);
            scores_d[i*K +: K]  = ovf_d[i] ? K'(SMAX) : K'(acc_d[i]);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_scores   = scores_q;
    assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_class_score_acc.sv
// Directed bench for class_score_acc: reset, saturation, score packing, gaps/backpressure, mid-run reset.
module tb_class_score_acc;
    localparam int unsigned N = 8;
    localparam int unsigned K = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    class_score_acc_if #(.N(N), .K(K), .W(W)) bus ();

    class_score_acc #(.N(N), .K(K), .W(W), .BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one beat starting at a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [N*W-1:0] bits);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bits  = bits;
        for (int t = 0; t < 20 && !done; t++) begin
            if (bus.in_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          tot [N];
        logic [63:0] v;
        int          rem;
        int          s;

        bus.in_valid  = 1'b1;
        bus.in_bits   = {$urandom, $urandom};
        bus.out_ready = 1'b0;

        // Reset held with a valid beat on the bus
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_scores", 64'(bus.out_scores), 64'h0);
        chk("rst_overflow", 64'(bus.out_overflow), 64'h0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // Saturation
        bus.out_ready = 1'b1;
        repeat (4) send({N*W{1'b1}});
        chk("sat_valid", 64'(bus.out_valid), 64'd1);
        chk("sat_scores", 64'(bus.out_scores), 64'hFFFFFFFF);
        chk("sat_overflow", 64'(bus.out_overflow), 64'hFF);
        @(negedge clk);
        chk("sat_valid_one_cycle", 64'(bus.out_valid), 64'd0);
        chk("sat_in_ready_back", 64'(bus.in_ready), 64'd1);

        // Score pattern: class totals 7..0 = 1,2,14,9,15,3,13,3
        tot = '{3, 13, 3, 15, 9, 14, 2, 1};
        for (int b = 0; b < 4; b++) begin
            v = '0;
            for (int i = 0; i < N; i++) begin
                rem = tot[i] - 8 * b;
                if (rem > 8) rem = 8;
                if (rem < 0) rem = 0;
                s = (1 << rem) - 1;
                v[i*W +: W] = 8'(s);
            end
            send(v);
        end
        chk("pat_valid", 64'(bus.out_valid), 64'd1);
        chk("pat_scores", 64'(bus.out_scores), 64'h12e9f3d3);
        chk("pat_overflow", 64'(bus.out_overflow), 64'h00);
        @(negedge clk);
        chk("pat_released", 64'(bus.out_valid), 64'd0);

        // Gapped single-bit beats with backpressure
        bus.out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send(64'h01);
            @(negedge clk);
        end
        chk("gap_valid", 64'(bus.out_valid), 64'd1);
        chk("gap_scores", 64'(bus.out_scores), 64'h00000004);
        bus.in_valid = 1'b1;
        bus.in_bits  = {N*W{1'b1}};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_scores", 64'(bus.out_scores), 64'h00000004);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("gap_released", 64'(bus.out_valid), 64'd0);
        repeat (4) send(64'h0);
        chk("zero_valid", 64'(bus.out_valid), 64'd1);
        chk("zero_scores", 64'(bus.out_scores), 64'h00000000);
        chk("zero_overflow", 64'(bus.out_overflow), 64'h00);
        @(negedge clk);

        // Reset in the middle of an inference
        repeat (2) send({N*W{1'b1}});
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_scores", 64'(bus.out_scores), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send(64'h03 << 56);
            chk("midrst_no_early_valid", 64'(bus.out_valid), 64'd0);
        end
        send(64'h03 << 56);
        chk("midrst_valid", 64'(bus.out_valid), 64'd1);
        chk("midrst_scores_final", 64'(bus.out_scores), 64'h80000000);
        chk("midrst_overflow", 64'(bus.out_overflow), 64'h00);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
